// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 reader.
//   state_t            - reader FSM states
//   BIT_THRESH_US      - high time (us) at or below which a data bit reads as 0
//   DEFAULT_TIMEOUT_US - default limit for any sensor-driven phase
//   BYTE_*             - byte positions inside the 40-bit frame (byte 0 arrives first)
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK
  } state_t;

  localparam int BIT_THRESH_US      = 40;
  localparam int DEFAULT_TIMEOUT_US = 200;

  localparam int BYTE_HUM_H  = 0;
  localparam int BYTE_HUM_L  = 1;
  localparam int BYTE_TEMP_H = 2;
  localparam int BYTE_TEMP_L = 3;
  localparam int BYTE_CSUM   = 4;
  localparam int FRAME_BYTES = 5;
  localparam int FRAME_BITS  = 8 * FRAME_BYTES;

endpackage

// File: rtl/dht11_reader_if.sv
// dht11_reader_if: sensor line and decoded-result signals of the DHT11 reader.
//   dht_in        - raw single-wire line level (asynchronous)
//   dht_drive_low - 1 = pull line low, 0 = release to pull-up
//   humidityH/L, tempH/L - last checksum-verified bytes
//   data_valid, crc_err, timeout_err - one-cycle result pulses
// master: the reader; slave: the sensor pad / consumer side.
interface dht11_reader_if;
  logic       dht_in;
  logic       dht_drive_low;
  logic [7:0] humidityH;
  logic [7:0] humidityL;
  logic [7:0] tempH;
  logic [7:0] tempL;
  logic       data_valid;
  logic       crc_err;
  logic       timeout_err;

  modport master (
    input  dht_in,
    output dht_drive_low, humidityH, humidityL, tempH, tempL,
    output data_valid, crc_err, timeout_err
  );

  modport slave (
    output dht_in,
    input  dht_drive_low, humidityH, humidityL, tempH, tempL,
    input  data_valid, crc_err, timeout_err
  );
endinterface

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: free-running 1 us strobe.
//   clk   - system clock (CLK_FREQ_HZ, a multiple of 1 MHz)
//   rst_n - asynchronous active-low reset
//   tick  - registered one-cycle pulse once per microsecond
module dht11_us_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg <= '0;
      tick    <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: periodically triggers a DHT11 measurement, decodes the 40-bit
// frame and publishes checksum-verified humidity/temperature bytes.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (also releases the line at once)
//   bus   - dht11_reader_if.master: line in/out, data bytes, result pulses
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int SAMPLE_PERIOD_MS = 2000,
  parameter int START_LOW_MS     = 20,
  parameter int TIMEOUT_US       = DEFAULT_TIMEOUT_US
) (
  input logic            clk,
  input logic            rst_n,
  dht11_reader_if.master bus
);

  logic tick;

  dht11_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one delayed copy for edge detection. Reset to
  // the idle (pulled-up) level so reset release never looks like a fall.
  logic [1:0] sync_reg;
  logic       dht_q_reg;
  logic       line_rise;
  logic       line_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b11;
      dht_q_reg <= 1'b1;
    end else begin
      sync_reg  <= {sync_reg[0], bus.dht_in};
      dht_q_reg <= sync_reg[1];
    end
  end

  assign line_rise = sync_reg[1] & ~dht_q_reg;
  assign line_fall = ~sync_reg[1] & dht_q_reg;

  state_t      state_reg;
  logic [15:0] phase_reg;   // us since state entry, saturating
  logic [9:0]  ms_div_reg;  // us within the current ms (IDLE/START timing)
  logic [15:0] ms_cnt_reg;  // ms since state entry, saturating
  logic [39:0] shift_reg;
  logic [5:0]  bit_cnt_reg;
  logic        drive_reg;
  logic [7:0]  hum_h_reg, hum_l_reg, temp_h_reg, temp_l_reg;
  logic        valid_reg, crc_err_reg, timeout_reg;

  // Frame bytes, byte 0 in the most significant position (MSB-first shift).
  logic [7:0] frame_bytes [FRAME_BYTES];
  for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_bytes
    assign frame_bytes[gi] = shift_reg[FRAME_BITS-1-8*gi -: 8];
  end

  logic [7:0] sum8;
  logic       sum_ok;
  assign sum8   = frame_bytes[BYTE_HUM_H] + frame_bytes[BYTE_HUM_L]
                + frame_bytes[BYTE_TEMP_H] + frame_bytes[BYTE_TEMP_L];
  assign sum_ok = (sum8 == frame_bytes[BYTE_CSUM]);

  // The phase count seen at an edge lags the true pulse width by one tick,
  // so ">= threshold" here means "high time > threshold" on the wire.
  logic timed_out;
  logic bit_value;
  assign timed_out = (phase_reg >= 16'(TIMEOUT_US));
  assign bit_value = (phase_reg >= 16'(BIT_THRESH_US));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      phase_reg   <= '0;
      ms_div_reg  <= '0;
      ms_cnt_reg  <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      drive_reg   <= 1'b0;
      hum_h_reg   <= '0;
      hum_l_reg   <= '0;
      temp_h_reg  <= '0;
      temp_l_reg  <= '0;
      valid_reg   <= 1'b0;
      crc_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      crc_err_reg <= 1'b0;
      timeout_reg <= 1'b0;

      if (tick && phase_reg != 16'hFFFF) phase_reg <= phase_reg + 16'd1;
      if (tick) begin
        if (ms_div_reg == 10'd999) begin
          ms_div_reg <= '0;
          if (ms_cnt_reg != 16'hFFFF) ms_cnt_reg <= ms_cnt_reg + 16'd1;
        end else begin
          ms_div_reg <= ms_div_reg + 10'd1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (ms_cnt_reg >= 16'(SAMPLE_PERIOD_MS)) begin
            state_reg  <= ST_START;
            drive_reg  <= 1'b1;
            phase_reg  <= '0;
            ms_div_reg <= '0;
            ms_cnt_reg <= '0;
          end
        end
        ST_START: begin
          if (ms_cnt_reg >= 16'(START_LOW_MS)) begin
            state_reg   <= ST_RELEASE;
            drive_reg   <= 1'b0;
            phase_reg   <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
          end
        end
        ST_CHECK: begin
          if (sum_ok) begin
            hum_h_reg  <= frame_bytes[BYTE_HUM_H];
            hum_l_reg  <= frame_bytes[BYTE_HUM_L];
            temp_h_reg <= frame_bytes[BYTE_TEMP_H];
            temp_l_reg <= frame_bytes[BYTE_TEMP_L];
            valid_reg  <= 1'b1;
          end else begin
            crc_err_reg <= 1'b1;
          end
          state_reg  <= ST_IDLE;
          phase_reg  <= '0;
          ms_div_reg <= '0;
          ms_cnt_reg <= '0;
        end
        default: begin
          // Sensor-driven phases share one timeout; the partial frame is
          // simply abandoned (it is cleared on the next START exit).
          if (timed_out) begin
            timeout_reg <= 1'b1;
            state_reg   <= ST_IDLE;
            phase_reg   <= '0;
            ms_div_reg  <= '0;
            ms_cnt_reg  <= '0;
          end else begin
            case (state_reg)
              ST_RELEASE:   if (line_fall) begin state_reg <= ST_RESP_LOW;  phase_reg <= '0; end
              ST_RESP_LOW:  if (line_rise) begin state_reg <= ST_RESP_HIGH; phase_reg <= '0; end
              ST_RESP_HIGH: if (line_fall) begin state_reg <= ST_BIT_LOW;   phase_reg <= '0; end
              ST_BIT_LOW:   if (line_rise) begin state_reg <= ST_BIT_HIGH;  phase_reg <= '0; end
              ST_BIT_HIGH: begin
                if (line_fall) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], bit_value};
                  phase_reg <= '0;
                  if (bit_cnt_reg == 6'(FRAME_BITS - 1)) begin
                    state_reg <= ST_CHECK;
                  end else begin
                    bit_cnt_reg <= bit_cnt_reg + 6'd1;
                    state_reg   <= ST_BIT_LOW;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.dht_drive_low = drive_reg;
  assign bus.humidityH     = hum_h_reg;
  assign bus.humidityL     = hum_l_reg;
  assign bus.tempH         = temp_h_reg;
  assign bus.tempL         = temp_l_reg;
  assign bus.data_valid    = valid_reg;
  assign bus.crc_err       = crc_err_reg;
  assign bus.timeout_err   = timeout_reg;

endmodule

// File: tb/tb_dht11_reader.sv
// tb_dht11_reader: drives a behavioural DHT11 sensor on the line and checks the
// reader's results against a frame-level model (bit = high time > 40 us,
// checksum = low byte of the sum of bytes 0..3).
module tb_dht11_reader;

  localparam int CLK_HZ = 1_000_000;
  localparam int SP_MS  = 5;
  localparam int SL_MS  = 1;
  localparam int TO_US  = 200;
  localparam int US     = 1000;  // time units per microsecond (one clock)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sensor_low = 1'b0;

  dht11_reader_if bus();
  assign bus.dht_in = ~(bus.dht_drive_low | sensor_low);

  dht11_reader #(
    .CLK_FREQ_HZ      (CLK_HZ),
    .SAMPLE_PERIOD_MS (SP_MS),
    .START_LOW_MS     (SL_MS),
    .TIMEOUT_US       (TO_US)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #(US/2) clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int dv_cnt = 0, crc_cnt = 0, to_cnt = 0, multi_cnt = 0;
  longint t_last_pulse = 0;
  logic [7:0] exp_hh = 8'h00, exp_hl = 8'h00, exp_th = 8'h00, exp_tl = 8'h00;
  int ht_tab [40];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.data_valid)  dv_cnt++;
    if (bus.crc_err)     crc_cnt++;
    if (bus.timeout_err) to_cnt++;
    if (int'(bus.data_valid) + int'(bus.crc_err) + int'(bus.timeout_err) > 1) multi_cnt++;
    if (bus.data_valid || bus.crc_err || bus.timeout_err) t_last_pulse = $time / US;
  end

  initial begin
    #(120_000 * US);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_drive(input logic lvl, input int max_us, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_us; i++) begin
      @(negedge clk);
      if (bus.dht_drive_low === lvl) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [39:0] build_frame(input logic [7:0] b0, b1, b2, b3, input bit bad);
    int s;
    logic [7:0] cs;
    s  = (int'(b0) + int'(b1) + int'(b2) + int'(b3)) % 256;
    if (bad) s = (s + int'($urandom_range(1, 255))) % 256;
    cs = 8'(s);
    return {b0, b1, b2, b3, cs};
  endfunction

  // Pick a high time for each wanted bit, favouring the 40/41 us boundary.
  task automatic make_ht(input logic [39:0] want);
    int r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 3));
      if (want[39-i]) ht_tab[i] = (r == 0) ? 41 : (r == 1) ? 70 : int'($urandom_range(41, 70));
      else            ht_tab[i] = (r == 0) ? 40 : (r == 1) ? 26 : int'($urandom_range(26, 40));
    end
  endtask

  function automatic logic [39:0] decode_ht();
    logic [39:0] f;
    for (int i = 0; i < 40; i++) f[39-i] = (ht_tab[i] > 40);
    return f;
  endfunction

  // Waits for a host start, then plays the sensor response from ht_tab.
  // silent: no response. abort_bit >= 0: assert reset during that bit's high.
  task automatic run_frame(input bit silent, input int abort_bit,
                           output longint t_start, output longint t_rel);
    bit seen;
    t_start = 0;
    t_rel   = 0;
    wait_drive(1'b1, SP_MS * 1000 + 3000, seen);
    check("start_seen", 32'(seen), 1);
    if (!seen) return;
    t_start = $time / US;
    wait_drive(1'b0, SL_MS * 1000 + 100, seen);
    check("release_seen", 32'(seen), 1);
    if (!seen) return;
    t_rel = $time / US;
    if (silent) return;
    #(30 * US); sensor_low = 1'b1;
    #(80 * US); sensor_low = 1'b0;
    #(80 * US);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      #(30 * US);
      sensor_low = 1'b0;
      if (i == abort_bit) begin
        #(10 * US);
        rst_n = 1'b0;
        #1;
        check("rst_drive_low", 32'(bus.dht_drive_low), 0);
        check("rst_bytes", {bus.humidityH, bus.humidityL, bus.tempH, bus.tempL}, 0);
        check("rst_pulses", {29'd0, bus.data_valid, bus.crc_err, bus.timeout_err}, 0);
        @(negedge clk);
        return;
      end
      #(ht_tab[i] * US);
    end
    sensor_low = 1'b1;
    #(50 * US);
    sensor_low = 1'b0;
    #(5 * US);
  endtask

  task automatic verify(input string name, input int dv0, input int crc0, input int to0);
    logic [39:0] f;
    int s;
    bit good;
    f    = decode_ht();
    s    = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    good = ((s % 256) == int'(f[7:0]));
    if (good) begin
      exp_hh = f[39:32]; exp_hl = f[31:24]; exp_th = f[23:16]; exp_tl = f[15:8];
    end
    check($sformatf("%s_data_valid", name), 32'(dv_cnt - dv0), 32'(good));
    check($sformatf("%s_crc_err", name), 32'(crc_cnt - crc0), 32'(!good));
    check($sformatf("%s_timeout", name), 32'(to_cnt - to0), 0);
    check($sformatf("%s_humH", name), 32'(bus.humidityH), 32'(exp_hh));
    check($sformatf("%s_humL", name), 32'(bus.humidityL), 32'(exp_hl));
    check($sformatf("%s_tempH", name), 32'(bus.tempH), 32'(exp_th));
    check($sformatf("%s_tempL", name), 32'(bus.tempL), 32'(exp_tl));
    $display("[%0d us] %s: frame %010h good=%0d -> hum %0d.%0d temp %0d.%0d",
             $time / US, name, f, good, bus.humidityH, bus.humidityL, bus.tempH, bus.tempL);
  endtask

  function automatic bit in_range(input longint v, input longint lo, input longint hi);
    return (v >= lo) && (v <= hi);
  endfunction

  initial begin
    longint t_reset, t_start, t_rel, p, d;
    int dv0, crc0, to0;
    logic [39:0] want;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_drive_low", 32'(bus.dht_drive_low), 0);
    check("reset_bytes", {bus.humidityH, bus.humidityL, bus.tempH, bus.tempL}, 0);
    check("reset_pulses", 32'(dv_cnt + crc_cnt + to_cnt), 0);
    rst_n   = 1'b1;
    t_reset = $time / US;

    // Frame A: 55 %RH, 25 C, good checksum
    dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
    make_ht(build_frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0));
    run_frame(1'b0, -1, t_start, t_rel);
    d = t_start - t_reset;
    check($sformatf("first_start_delay_%0dus", d), 32'(in_range(d, 4999, 5003)), 1);
    d = t_rel - t_start;
    check($sformatf("start_low_width_%0dus", d), 32'(in_range(d, 999, 1002)), 1);
    verify("frameA", dv0, crc0, to0);
    p = t_last_pulse;

    // Frame B: same data, checksum 0x51
    dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
    make_ht({8'h37, 8'h00, 8'h19, 8'h00, 8'h51});
    run_frame(1'b0, -1, t_start, t_rel);
    d = t_start - p;
    check($sformatf("period_after_frameA_%0dus", d), 32'(in_range(d, 4999, 5003)), 1);
    d = t_rel - t_start;
    check($sformatf("start_low_width_B_%0dus", d), 32'(in_range(d, 999, 1002)), 1);
    verify("frameB", dv0, crc0, to0);

    // Frame C: sensor silent -> timeout
    dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
    run_frame(1'b1, -1, t_start, t_rel);
    for (int i = 0; i < 2 * TO_US && to_cnt == to0; i++) @(negedge clk);
    check("timeout_pulse", 32'(to_cnt - to0), 1);
    d = t_last_pulse - t_rel;
    check($sformatf("timeout_delay_%0dus", d), 32'(in_range(d, TO_US - 1, TO_US + 2)), 1);
    check("timeout_no_dv", 32'(dv_cnt - dv0), 0);
    check("timeout_no_crc", 32'(crc_cnt - crc0), 0);
    check("timeout_hold_bytes", {bus.humidityH, bus.humidityL, bus.tempH, bus.tempL},
          {exp_hh, exp_hl, exp_th, exp_tl});
    $display("[%0d us] frameC: silent sensor, timeout after %0d us", $time / US, d);
    p = t_last_pulse;

    // Frame D: threshold bits 26/40/41/70 us at the front, random rest
    dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
    want = build_frame({4'b0011, 4'($urandom_range(0, 15))}, 8'($urandom_range(0, 255)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                       $urandom_range(0, 3) == 0);
    make_ht(want);
    ht_tab[0] = 26; ht_tab[1] = 40; ht_tab[2] = 41; ht_tab[3] = 70;
    run_frame(1'b0, -1, t_start, t_rel);
    d = t_start - p;
    check($sformatf("period_after_timeout_%0dus", d), 32'(in_range(d, 4999, 5003)), 1);
    verify("frameD", dv0, crc0, to0);

    // Frame E: reset during the high phase of bit 20
    dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
    make_ht(build_frame(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)), 1'b0));
    run_frame(1'b0, 20, t_start, t_rel);
    repeat (3) @(negedge clk);
    check("abort_no_pulses", 32'((dv_cnt - dv0) + (crc_cnt - crc0) + (to_cnt - to0)), 0);
    check("abort_bytes_held_zero", {bus.humidityH, bus.humidityL, bus.tempH, bus.tempL}, 0);
    $display("[%0d us] frameE: reset asserted in bit 20", $time / US);
    exp_hh = 8'h00; exp_hl = 8'h00; exp_th = 8'h00; exp_tl = 8'h00;
    rst_n   = 1'b1;
    t_reset = $time / US;

    // Frame F: clean random frame after the aborted one
    dv0 = dv_cnt; crc0 = crc_cnt; to0 = to_cnt;
    make_ht(build_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0));
    run_frame(1'b0, -1, t_start, t_rel);
    d = t_start - t_reset;
    check($sformatf("start_after_reset_%0dus", d), 32'(in_range(d, 4999, 5003)), 1);
    verify("frameF", dv0, crc0, to0);

    check("exclusive_pulses", 32'(multi_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dht11_reader.md
# dht11_reader

Single-wire DHT11 sensor front end that periodically triggers a measurement and decodes the 40-bit response frame. Its checksum-verified humidity and temperature bytes feed the 16x2 LCD display stage's tempH/tempL/humidityH/humidityL inputs. Last good values are held between measurements.

## Interface
- CLK_FREQ_HZ, 50_000_000: system clock frequency; must be a multiple of 1 MHz.
- SAMPLE_PERIOD_MS, 2000: interval between measurement starts (≥1000 for the real sensor).
- START_LOW_MS, 20: host start pulse length.
- TIMEOUT_US, 200: maximum duration of any sensor-driven phase.
- clk, input, 1: system clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- dht_in, input, 1: raw data line level, asynchronous to clk.
- dht_drive_low, output, 1: 1 = pull line low (top level drives 0); 0 = release to pull-up (Z).
- humidityH, output, 8: humidity integer byte.
- humidityL, output, 8: humidity decimal byte.
- tempH, output, 8: temperature integer byte.
- tempL, output, 8: temperature decimal byte.
- data_valid, output, 1: one-cycle pulse when all four bytes update.
- crc_err, output, 1: one-cycle pulse on checksum mismatch.
- timeout_err, output, 1: one-cycle pulse on phase timeout.

## Operation
- dht_in passes through a 2-FF synchronizer. All protocol decisions use the synchronized level.
- A free-running 1 µs tick divides CLK_FREQ_HZ/1e6. A phase counter (µs, 16 bit) clears on every state entry and saturates at its maximum.
- FSM states and transitions:
  - IDLE: line released. Waits SAMPLE_PERIOD_MS, then goes to START.
  - START: dht_drive_low=1 for START_LOW_MS, then goes to RELEASE.
  - RELEASE: line released. Goes to RESP_LOW when the line goes low.
  - RESP_LOW: goes to RESP_HIGH when the line goes high.
  - RESP_HIGH: goes to BIT_LOW when the line goes low.
  - BIT_LOW: goes to BIT_HIGH when the line goes high.
  - BIT_HIGH: on the falling edge, shifts in bit = (high time > 40 µs), MSB first. After 40 bits it goes to CHECK, otherwise to BIT_LOW.
  - CHECK: runs for one cycle, then goes to IDLE.
- Timeout: if RELEASE, RESP_*, or BIT_* lasts longer than TIMEOUT_US, pulse timeout_err, discard the partial frame and go to IDLE.
- Frame order: byte0 humidityH, byte1 humidityL, byte2 tempH, byte3 tempL, byte4 checksum.
- CHECK rule: (byte0+byte1+byte2+byte3) mod 256 == byte4.
  - Match: load all four outputs and pulse data_valid.
  - Mismatch: pulse crc_err; outputs stay unchanged.
- The first measurement starts SAMPLE_PERIOD_MS after reset release. This covers the sensor power-up time.
- A high pulse of exactly 40 µs decodes as 0.

## Timing
- Reset values: dht_drive_low=0, all data bytes 0x00, all pulses 0, FSM in IDLE, counters 0.
- Reset mid-transaction: the line is released immediately (dht_drive_low is cleared asynchronously) and no outputs update.
- Edge detection latency: 2 clk synchronizer + 1 clk state register. Timing measurements have ±1 µs resolution.
- Data bytes and data_valid change in the same clk edge, one cycle after the 40th falling edge is detected in CHECK.
- data_valid, crc_err and timeout_err are mutually exclusive. Each fires at most once per measurement.
- Measurement period runs from START entry to START entry: SAMPLE_PERIOD_MS + START_LOW_MS + frame time. There is no drift compensation.

## Structure
- Package dht11_pkg holds:
  - the state enum,
  - µs constants for the 40 µs bit threshold and default timeout,
  - the frame byte-index constants.
- One sub-module, dht11_us_tick, is the 1 µs strobe generator, parameterized by CLK_FREQ_HZ.
- The synchronizer, FSM, shift register and checksum logic stay in dht11_reader.

## Test plan
- Sensor model sends 0x37,0x00,0x19,0x00,0x50 -> humidityH=55, tempH=25, L bytes 0, one data_valid pulse.
- Same frame with checksum 0x51 -> crc_err pulse; outputs keep previous values 55/25; no data_valid.
- Sensor silent after release -> timeout_err exactly TIMEOUT_US (±1 µs) after RELEASE entry; FSM returns to IDLE; next START follows one period later.
- Bit high times of 26, 40, 41 and 70 µs -> decoded 0, 0, 1, 1.
- Assert rst_n during BIT_HIGH of bit 20 -> dht_drive_low=0 and outputs 0x00 asynchronously; no pulses; a clean frame after release decodes correctly.
- Use SAMPLE_PERIOD_MS=5, START_LOW_MS=1 -> dht_drive_low high for 1 ms ±1 µs, starting 5 ms after reset, and repeating every measurement.
